ref_dram_responder: RTL
=======================

Name: ref_dram_responder

Overview:
- Responder side of the reference-frame prefetch DRAM request protocol (issue_req / addr / len / dram_ack), which split_prefetcher drives as initiator.
- Accepts one burst request at a time, acknowledges it, and reads the words from on-chip reference memory.
- Streams the words to DPM as ref_data / ref_data_valid, with consumer backpressure.
- Sits between split_prefetcher, the reference SRAM, and dpm.

Parameters:
- DATA_W, 16, word width in bits (2 bytes per word).
- ADDR_WIDTH, 32, byte-address width of the request.
- LEN_W, 16, width of len (count in words).
- MEM_ADDR_W, 20, word-address width of the reference SRAM.
- FIFO_DEPTH, 4, output buffer depth in words; power of two, at least 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_req  in  1  request; initiator holds it high until dram_ack.
- addr  in  ADDR_WIDTH  burst start byte address; bit 0 is ignored.
- len  in  LEN_W  burst length in words; 0 is legal.
- dram_ack  out  1  one-cycle acceptance pulse.
- mem_rd_en  out  1  SRAM read strobe.
- mem_rd_addr  out  MEM_ADDR_W  SRAM word address.
- mem_rd_data  in  DATA_W  SRAM data; valid exactly 1 cycle after the mem_rd_en cycle.
- ref_data  out  DATA_W  streamed word (head of the FIFO).
- ref_data_valid  out  1  ref_data is valid.
- ref_ready  in  1  consumer accepts ref_data this cycle.
- burst_done  out  1  one-cycle pulse when the last word of a burst has been consumed.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, counters 0, in-flight flag cleared. Reset mid-burst abandons the burst. SRAM data returning in the cycle after reset is discarded. No burst_done is generated for the abandoned burst.
- States: IDLE, READ, DRAIN.
- IDLE, issue_req=1 at edge E0:
  - dram_ack=1 for exactly the cycle after E0.
  - Latch base = addr[MEM_ADDR_W:1] and remaining = len.
  - Go to READ.
  - issue_req still high during the ack cycle must not be re-accepted. A new request is accepted only in IDLE.
- READ:
  - mem_rd_en = (remaining != 0) && (fifo_count + inflight < FIFO_DEPTH). It is combinational from registered state.
  - mem_rd_addr = base + issued, modulo 2^MEM_ADDR_W, so address wrap-around is silent.
  - Each strobe increments issued, decrements remaining, and sets inflight for the next cycle.
  - The next edge writes mem_rd_data into the FIFO when inflight=1.
  - When remaining reaches 0, go to DRAIN.
- DRAIN: when inflight=0 and the FIFO is empty, pulse burst_done for one cycle, drop busy, and go to IDLE.
- len=0: READ moves to DRAIN immediately. burst_done pulses 2 cycles after the dram_ack cycle, and mem_rd_en is never asserted.
- Output handshake (first-word fall-through):
  - ref_data_valid = FIFO non-empty; ref_data = FIFO head.
  - A word transfers when ref_data_valid && ref_ready. ref_data and ref_data_valid must hold stable while ref_ready=0.
  - FIFO push and pop in the same cycle leave the count unchanged.
- Overflow and throughput:
  - The FIFO can never overflow, because reads are credit-limited by fifo_count + inflight.
  - With ref_ready held at 1, throughput is 1 word per cycle.
  - First ref_data_valid is 2 cycles after the dram_ack cycle.
- Latency: the last word is consumed in the cycle before burst_done; burst_done is registered.
- Counters issued and remaining are LEN_W bits wide. fifo_count is log2(FIFO_DEPTH)+1 bits wide.

Test Plan:
- Basic burst: addr=0x100, len=4, SRAM[0x80+i]=0xA0+i, ref_ready=1 -> dram_ack 1 cycle, mem_rd_addr 0x80..0x83 on 4 consecutive cycles, ref_data 0xA0..0xA3 on 4 consecutive cycles starting 2 cycles after ack, burst_done 1 cycle after last transfer.
- Backpressure: len=8, ref_ready=0 for 10 cycles then 1 -> exactly 4 reads issued then mem_rd_en=0, ref_data stays 0xA0 while stalled, all 8 words delivered in order, no loss or duplication.
- Zero length: len=0 -> dram_ack once, no mem_rd_en, no ref_data_valid, burst_done 2 cycles after ack, busy low afterward.
- Wrap: addr = 2*(2^MEM_ADDR_W - 2), len=4 -> mem_rd_addr sequence 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- Held request: issue_req kept high across 2 back-to-back bursts -> exactly one dram_ack per burst, second ack only after the first burst_done.
- Reset mid-burst: rst=1 for 1 cycle after 2 of 6 words delivered -> all outputs 0 next cycle, no burst_done, a new request afterward completes normally.

Source files
------------

// File: rtl/ref_dram_responder.sv
// ref_dram_responder: burst responder for reference-frame prefetch.
// Reads SRAM words under FIFO credit and streams them first-word fall-through.
module ref_dram_responder #(
  parameter int DATA_W     = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_W      = 16,
  parameter int MEM_ADDR_W = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_W-1:0]      len,
  output logic                  dram_ack,
  output logic                  mem_rd_en,
  output logic [MEM_ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0]     mem_rd_data,
  output logic [DATA_W-1:0]     ref_data,
  output logic                  ref_data_valid,
  input  logic                  ref_ready,
  output logic                  burst_done,
  output logic                  busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_ack;
  logic                  r_done;
  logic                  r_inflight;
  logic [MEM_ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]      r_issued;
  logic [LEN_W-1:0]      r_remaining;
  logic [LEN_W-1:0]      w_rem_nxt;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_nxt;
  logic [DATA_W-1:0]     r_mem [FIFO_DEPTH];
  logic [CW:0]           w_credit;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_rd_en;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid;
  logic                  w_unused_addr;

  assign w_unused_addr =
    ^{addr[ADDR_WIDTH-1:MEM_ADDR_W+1], addr[0]};

  assign w_credit = {1'b0, r_count}
                  + {{CW{1'b0}}, r_inflight};

  assign w_rd_en = (r_state == S_READ)
                && (r_remaining != '0)
                && (w_credit < (CW+1)'(FIFO_DEPTH));

  assign w_rem_nxt = w_rd_en
                   ? r_remaining - LEN_W'(1)
                   : r_remaining;

  assign w_push      = r_inflight;
  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid && ref_ready;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  assign dram_ack       = r_ack;
  assign burst_done     = r_done;
  assign busy           = (r_state != S_IDLE);
  assign mem_rd_en      = w_rd_en;
  assign mem_rd_addr    = w_rd_en
                        ? r_base + MEM_ADDR_W'(r_issued)
                        : '0;
  assign ref_data_valid = w_valid;
  assign ref_data       = w_valid ? r_mem[r_rd_ptr] : '0;

  // next state, request acceptance and burst completion
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (issue_req) begin
          w_accept    = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (w_rem_nxt == '0) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!r_inflight && w_count_nxt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state register and registered ack/done pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_accept;
      r_done  <= w_done;
    end
  end

  // burst bookkeeping: base, issued/remaining, read in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base      <= '0;
      r_issued    <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_accept) begin
        r_base      <= addr[MEM_ADDR_W:1];
        r_issued    <= '0;
        r_remaining <= len;
      end else if (w_rd_en) begin
        r_issued    <= r_issued + LEN_W'(1);
        r_remaining <= w_rem_nxt;
      end
    end
  end

  // output FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
    end
  end

  // output FIFO storage; SRAM data lands one cycle after the strobe
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= mem_rd_data;
  end

endmodule
